// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int          FETCH_ADDR_W   = 12;
  localparam int          FETCH_INSTR_W  = 16;
  localparam int unsigned FETCH_RESET_PC = 0;

  // Default-width queue entry; fetch_unit re-declares it at its own widths.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int ptr_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: instruction-memory request/response plus the decode-side handshake.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
);
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_req;
  logic [INSTR_W-1:0] imem_q;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    output imem_addr, imem_req, out_valid, out_pc, out_instr,
    input  imem_q, out_ready
  );

  modport slave (
    input  imem_addr, imem_req, out_valid, out_pc, out_instr,
    output imem_q, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO: flush has priority over push/pop, no bypass path.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  entry_t                    push_data,
  input  logic                      pop,
  output logic [ptr_w(DEPTH+1)-1:0] count,
  output entry_t                    head
);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single in-flight imem request, credit-gated prefetch queue.
// Optional FETCH_STATS_EN adds saturating handshake/redirect/bubble counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_redirects,
  output logic [31:0]       stat_bubbles
`endif
);
  localparam int CW = ptr_w(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc, inflight_pc;
  logic              inflight, fetch, push, pop, valid;
  logic [CW-1:0]     count;
  entry_t            push_data, head;

  // Credit: a request is only issued if its response is guaranteed a slot.
  assign valid = reset & (count != '0);
  assign fetch = reset & run & ~redirect &
                 (({1'b0, count} + (CW+1)'(inflight)) < DEPTH_L);
  assign pop   = valid & bus.out_ready & ~redirect;
  assign push  = inflight & ~redirect;

  assign push_data.pc    = inflight_pc;
  assign push_data.instr = bus.imem_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= fetch;
      if (fetch) begin
        pc          <= pc + 1'b1;
        inflight_pc <= pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign bus.imem_addr = reset ? pc : RESET_PC;
  assign bus.imem_req  = fetch;
  assign bus.out_valid = valid;
  assign bus.out_pc    = valid ? head.pc    : '0;
  assign bus.out_instr = valid ? head.instr : '0;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_fetched   <= '0;
      stat_redirects <= '0;
      stat_bubbles   <= '0;
    end else begin
      if (pop && stat_fetched != '1)        stat_fetched   <= stat_fetched + 32'd1;
      if (redirect && stat_redirects != '1) stat_redirects <= stat_redirects + 32'd1;
      if (bus.out_ready && !valid && run && stat_bubbles != '1)
        stat_bubbles <= stat_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random run/ready/redirect/reset against a stream-level model.
module tb_fetch_unit;
  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;
  localparam logic [ADDR_W-1:0] RST_PC = 12'h010;

  logic              clock = 1'b0;
  logic              reset, run, redirect, out_ready;
  logic [ADDR_W-1:0] redirect_pc;
  int                checks = 0;
  int                errors = 0;

  logic [INSTR_W-1:0] img [4096];

  // Model: fetch PC, next PC decode should see, requests not yet delivered, request awaiting response.
  logic [ADDR_W-1:0] m_fpc = '0, m_dpc = '0;
  int                m_out = 0;
  bit                m_pend = 1'b0;
  int                m_fetched = 0, m_redir = 0, m_bub = 0;

  logic               obs_valid, obs_req;
  logic [ADDR_W-1:0]  obs_pc;
  logic [INSTR_W-1:0] obs_instr;

  always #5 clock = ~clock;

  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();
  assign bus.out_ready = out_ready;

  // Instruction memory: data valid the cycle after the request, noise otherwise.
  always @(posedge clock)
    bus.imem_q <= bus.imem_req ? img[bus.imem_addr] : 16'($urandom);

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_redirects, stat_bubbles;
`endif

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_redirects (stat_redirects),
    .stat_bubbles   (stat_bubbles)
`endif
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic cyc();
    logic ev, er;
    @(negedge clock);
    obs_valid = bus.out_valid;
    obs_req   = bus.imem_req;
    obs_pc    = bus.out_pc;
    obs_instr = bus.out_instr;
    ev = reset && ((m_out - int'(m_pend)) > 0);
    er = reset && run && !redirect && (m_out < DEPTH);
    chk("imem_req", obs_req, er);
    chk("imem_addr", bus.imem_addr, reset ? m_fpc : RST_PC);
    chk("out_valid", obs_valid, ev);
    if (ev) begin
      chk("out_pc", obs_pc, m_dpc);
      chk("out_instr", obs_instr, img[m_dpc]);
    end else if (!reset) begin
      chk("rst_out_pc", obs_pc, 0);
      chk("rst_out_instr", obs_instr, 0);
    end
    if (!reset) begin
      m_fpc = RST_PC; m_dpc = RST_PC; m_out = 0; m_pend = 0;
      m_fetched = 0; m_redir = 0; m_bub = 0;
    end else begin
      if (out_ready && !ev && run) m_bub++;
      if (redirect) begin
        m_fpc = redirect_pc; m_dpc = redirect_pc; m_out = 0; m_pend = 0; m_redir++;
      end else begin
        if (ev && out_ready) begin m_dpc++; m_out--; m_fetched++; end
        m_pend = er;
        if (er) begin m_fpc++; m_out++; end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (obs_valid) begin n = i; break; end
    end
  endtask

  initial begin
    int n, cnt, reqs;
    for (int a = 0; a < 4096; a++) img[a] = 16'($urandom);
    reset = 0; run = 1; redirect = 0; out_ready = 1; redirect_pc = '0;
    repeat (3) cyc();

    // Reset release: first delivery on the 3rd cycle, then consecutive PCs.
    reset = 1;
    wait_valid(n);
    chk("rst_latency", n, 3);
    chk("rst_pc0", obs_pc, 12'h010);
    chk("rst_instr0", obs_instr, img[12'h010]);
    cyc(); chk("rst_pc1", obs_pc, 12'h011);
    cyc(); chk("rst_pc2", obs_pc, 12'h012);

    // Back-pressure fills exactly DEPTH entries, then drains in order.
    out_ready = 0;
    repeat (10) cyc();
    chk("stall_req", obs_req, 0);
    run = 0; out_ready = 1; cnt = 0;
    repeat (8) begin cyc(); if (obs_valid) cnt++; end
    chk("stall_held", cnt, DEPTH);
    run = 1;

    // Redirect with 3 queued + 1 in flight.
    out_ready = 0; redirect = 1; redirect_pc = 12'h100; cyc(); redirect = 0;
    repeat (4) cyc();
    redirect = 1; redirect_pc = 12'h200; cyc(); redirect = 0;
    out_ready = 1;
    wait_valid(n);
    chk("redir_latency", n, 3);
    chk("redir_pc", obs_pc, 12'h200);

    // Redirect coinciding with a ready head: head not delivered.
    out_ready = 0; redirect = 1; redirect_pc = 12'h005; cyc(); redirect = 0;
    wait_valid(n);
    chk("head5_latency", n, 3);
    chk("head5_pc", obs_pc, 12'h005);
    out_ready = 1; redirect = 1; redirect_pc = 12'h300; cyc(); redirect = 0;
    chk("head5_seen", obs_pc, 12'h005);
`ifdef FETCH_STATS_EN
    chk("stat_fetched_hold", stat_fetched, m_fetched);
`endif
    wait_valid(n);
    chk("redir300_latency", n, 3);
    chk("redir300_pc", obs_pc, 12'h300);

    // PC wrap at ADDR_W.
    redirect = 1; redirect_pc = 12'hFFE; cyc(); redirect = 0;
    wait_valid(n);
    chk("wrap_pc0", obs_pc, 12'hFFE);
    cyc(); chk("wrap_pc1", obs_pc, 12'hFFF);
    cyc(); chk("wrap_pc2", obs_pc, 12'h000);

    // run low: no requests, in-flight still delivered, resume without skipping.
    run = 0; cnt = 0; reqs = 0;
    repeat (5) begin
      cyc();
      if (obs_req) reqs++;
      if (obs_valid) cnt++;
    end
    chk("runlow_reqs", reqs, 0);
    chk("runlow_drain", cnt, 2);
    run = 1;
    wait_valid(n);
    chk("resume_latency", n, 3);
    chk("resume_pc", obs_pc, 12'h003);

    // Random traffic including redirects and mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      run         = ($urandom_range(0, 9) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 12'($urandom);
      reset       = ($urandom_range(0, 99) != 0);
      cyc();
    end
    reset = 1; redirect = 0; run = 1; out_ready = 1;
    repeat (6) cyc();

`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, m_fetched);
    chk("stat_redirects", stat_redirects, m_redir);
    chk("stat_bubbles", stat_bubbles, m_bub);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined core; owns the PC and drives the instruction memory.
- Delivers {pc, instr} pairs to decode over a valid/ready handshake, buffered in a small prefetch queue, so decode back-pressure and load-use stalls never drop an in-flight fetch.
- Takes branch redirects from the branch-resolve stage: flushes the queue and discards the in-flight response.
- Generalises the hard-wired 12/16-bit fetch with its never-asserted stall into configurable widths, queue depth and reset vector.

Parameters:
ADDR_W, 12, instruction memory address and PC width
INSTR_W, 16, instruction width
DEPTH, 4, prefetch queue entries (min 2; full throughput needs >= 3)
RESET_PC, 0, PC loaded on reset (ADDR_W bits)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
run  in  1  fetch enable (core exec); low = issue no new requests
redirect  in  1  branch taken, single-cycle pulse
redirect_pc  in  ADDR_W  branch target
imem_addr  out  ADDR_W  instruction memory address
imem_req  out  1  request issued this cycle
imem_q  in  INSTR_W  read data, valid exactly 1 cycle after imem_req
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  ADDR_W  PC of head instruction
out_instr  out  INSTR_W  head instruction

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a rising edge): pc=RESET_PC, queue empty, inflight=0. Outputs during and after reset: out_valid=0, imem_req=0, out_pc/out_instr=0, imem_addr=RESET_PC.
- imem_addr = pc (combinational). imem_req = run & !redirect & (count + inflight < DEPTH).
- On imem_req at an edge: inflight<=1, inflight_pc<=pc, pc<=pc+1, modulo 2^ADDR_W (0xFFF wraps to 0x000 at ADDR_W=12).
- Response: in the cycle after a request, imem_q is enqueued with tag inflight_pc; inflight clears unless a new request was issued.
- Queue: synchronous FIFO, no bypass. Request-to-out_valid latency is 2 cycles.
- out_valid = count>0. Handshake fires when out_valid & out_ready. out_pc/out_instr stay stable while out_valid & !out_ready.
- A simultaneous enqueue and dequeue leaves count unchanged.
- Credit rule: count + inflight <= DEPTH always, so an arriving response never overflows the queue.
- Redirect, sampled high at an edge:
  - pc<=redirect_pc, queue cleared, inflight cleared.
  - A response arriving the next cycle is dropped.
  - The same cycle's dequeue and request are suppressed; redirect wins over everything.
  - The first out_valid with out_pc==redirect_pc appears 3 cycles after the redirect cycle, if run is high.
- run low: no new requests. An outstanding response is still enqueued and the queue still drains. Redirect while run is low still updates pc and flushes.
- Back-to-back redirects: the last one wins. Each redirect flushes.
- Reset asserted mid-operation overrides redirect and handshake. Outstanding data is discarded.

Optional Feature:
- FETCH_STATS_EN defined adds output ports stat_fetched[31:0], stat_redirects[31:0] and stat_bubbles[31:0]:
  - stat_fetched counts handshakes.
  - stat_redirects counts redirect cycles.
  - stat_bubbles counts cycles with out_ready & !out_valid & run.
  - All counters saturate at 0xFFFFFFFF and clear on reset.
- Macro undefined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package fetch_pkg: RESET_PC default, the DEPTH-to-pointer-width helper (clog2), and the queue entry struct {pc, instr}.
- Sub-module fetch_queue holds the parametrised sync FIFO: push, pop, flush, count, head. It is flush-priority and has no bypass.
- fetch_unit keeps the PC, inflight tracking, credit logic and stats.

Test Plan:
- Reset with RESET_PC=0x010, run=1, out_ready=1 -> out_pc 0x010, 0x011, 0x012 on consecutive cycles; first out_valid on the 3rd cycle after reset release; out_instr matches the memory image.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 entries held, imem_req=0 once count+inflight=4; on release, in-order delivery with no gap or duplicate.
- Redirect to 0x200 while the queue holds 3 entries and one request is in flight -> the 3 entries and the arriving response never appear; next out_pc=0x200 exactly 3 cycles later.
- Redirect and out_ready=1 in the same cycle with the head at 0x005 -> head 0x005 not counted as delivered; stat_fetched unchanged (FETCH_STATS_EN).
- pc=0xFFE, ADDR_W=12 -> out_pc sequence 0xFFE, 0xFFF, 0x000.
- run dropped for 5 cycles mid-stream -> no imem_req; the in-flight instruction is still delivered; on resume, no PC skipped.
